// File: rtl/robot_sense_pkg.sv
// Shared constants, state encodings and sizing helper for the robot
// sensor-conditioning block.
package robot_sense_pkg;

  localparam int N_CH_DEF     = 5;
  localparam int DEBOUNCE_DEF = 4;
  localparam int GCNT_W_DEF   = 8;

  typedef enum logic {CH_STABLE, CH_PENDING} ch_state_e;
  typedef enum logic {TOP_INIT,  TOP_RUN}    top_state_e;

  // Counter wide enough to hold 0..DEBOUNCE.
  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/robot_debounce_ch.sv
// One sensor channel: 2-flop synchronizer followed by a consecutive-sample
// debounce FSM that reports level-change and rejected-glitch events.
module robot_debounce_ch
  import robot_sense_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_q,
  output logic o_q_next,
  output logic o_change,
  output logic o_glitch
);

  localparam int            CW       = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          r_s1, r_s2, r_q;
  logic [CW-1:0] r_cnt;
  ch_state_e     r_state;

  logic          w_q_next, w_change, w_glitch;
  logic [CW-1:0] w_cnt_next;
  ch_state_e     w_state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
      r_state <= CH_STABLE;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_q_next     = r_q;
    w_change     = 1'b0;
    w_glitch     = 1'b0;
    case (r_state)
      CH_STABLE: begin
        if (r_s2 != r_q) begin
          w_state_next = CH_PENDING;
          w_cnt_next   = CW'(1);
        end else begin
          w_cnt_next   = '0;
        end
      end
      CH_PENDING: begin
        if (r_s2 == r_q) begin
          w_state_next = CH_STABLE;
          w_cnt_next   = '0;
          w_glitch     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = CH_STABLE;
          w_cnt_next   = '0;
          w_q_next     = ~r_q;
          w_change     = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + CW'(1);
        end
      end
    endcase
  end

  assign o_q      = r_q;
  assign o_q_next = w_q_next;
  assign o_change = w_change;
  assign o_glitch = w_glitch;

endmodule

// File: rtl/robot_sensor_conditioner.sv
// Conditions the raw limit-switch lines into clean x1..x5 levels with edge
// pulses, a power-up ready flag and a saturating glitch counter.
module robot_sensor_conditioner
  import robot_sense_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int GCNT_W   = GCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   raw_in,
  input  logic              glitch_clr,
  output logic [N_CH-1:0]   x_out,
  output logic [N_CH-1:0]   rise,
  output logic [N_CH-1:0]   fall,
  output logic              ready,
  output logic [GCNT_W-1:0] glitch_count
);

  localparam int                INIT_W    = $clog2(DEBOUNCE + 2);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE + 1);
  localparam int                POP_W     = $clog2(N_CH + 1);
  localparam int                SUM_W     = GCNT_W + 1;
  localparam logic [SUM_W-1:0]  GCNT_MAX  = {1'b0, {GCNT_W{1'b1}}};

  logic [N_CH-1:0] w_q, w_q_next, w_change, w_glitch;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    robot_debounce_ch #(.DEBOUNCE(DEBOUNCE)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (raw_in[i]),
      .o_q      (w_q[i]),
      .o_q_next (w_q_next[i]),
      .o_change (w_change[i]),
      .o_glitch (w_glitch[i])
    );
  end

  top_state_e        r_state, w_state_next;
  logic [INIT_W-1:0] r_init_cnt, w_init_cnt_next;
  logic              w_load;

  logic [N_CH-1:0]   r_x, r_rise, r_fall, w_x_next, w_rise_next, w_fall_next;
  logic              r_ready, w_ready_next;
  logic [GCNT_W-1:0] r_gcnt, w_gcnt_next;
  logic [POP_W-1:0]  w_pop;
  logic [SUM_W-1:0]  w_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= TOP_INIT;
      r_init_cnt <= '0;
      r_x        <= '0;
      r_rise     <= '0;
      r_fall     <= '0;
      r_ready    <= 1'b0;
      r_gcnt     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
      r_x        <= w_x_next;
      r_rise     <= w_rise_next;
      r_fall     <= w_fall_next;
      r_ready    <= w_ready_next;
      r_gcnt     <= w_gcnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_load          = 1'b0;
    case (r_state)
      TOP_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_next = TOP_RUN;
          w_load       = 1'b1;
        end else begin
          w_init_cnt_next = r_init_cnt + INIT_W'(1);
        end
      end
      TOP_RUN: w_state_next = TOP_RUN;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_CH; i++) w_pop = w_pop + POP_W'(w_glitch[i]);
  end

  assign w_sum = SUM_W'(r_gcnt) + SUM_W'(w_pop);

  // x_out tracks the channel's next level so it moves on the same edge as q.
  always_comb begin
    w_x_next     = '0;
    w_rise_next  = '0;
    w_fall_next  = '0;
    w_ready_next = 1'b0;
    w_gcnt_next  = r_gcnt;
    if (r_state == TOP_RUN) begin
      w_x_next     = w_q_next;
      w_rise_next  = w_change & ~w_q;
      w_fall_next  = w_change & w_q;
      w_ready_next = 1'b1;
      if (glitch_clr)            w_gcnt_next = '0;
      else if (w_sum > GCNT_MAX) w_gcnt_next = GCNT_MAX[GCNT_W-1:0];
      else                       w_gcnt_next = w_sum[GCNT_W-1:0];
    end else if (w_load) begin
      w_x_next     = w_q_next;
      w_ready_next = 1'b1;
    end
  end

  assign x_out        = r_x;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign ready        = r_ready;
  assign glitch_count = r_gcnt;

endmodule

// File: tb/tb_robot_sensor_conditioner.sv
// Directed bench for robot_sensor_conditioner: a per-cycle vector table for
// settle/edge/bounce behaviour plus sequences for saturation and mid-run reset.
module tb_robot_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] raw_in = 5'b01000;
  logic       glitch_clr = 1'b0;
  logic [4:0] x_out, rise, fall;
  logic       ready;
  logic [7:0] glitch_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_g;

  robot_sensor_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .raw_in       (raw_in),
    .glitch_clr   (glitch_clr),
    .x_out        (x_out),
    .rise         (rise),
    .fall         (fall),
    .ready        (ready),
    .glitch_count (glitch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] x;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       ready;
    logic [7:0] gcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic [4:0] raw, input logic [4:0] x,
                       input logic [4:0] r, input logic [4:0] f,
                       input logic rdy, input logic [7:0] g);
    vec_t v;
    v.raw = raw; v.x = x; v.rise = r; v.fall = f; v.ready = rdy; v.gcnt = g;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [4:0] x, input logic [4:0] r,
                           input logic [4:0] f, input logic rdy, input logic [7:0] g);
    check({tag, ".x_out"},        32'(x_out),        32'(x));
    check({tag, ".rise"},         32'(rise),         32'(r));
    check({tag, ".fall"},         32'(fall),         32'(f));
    check({tag, ".ready"},        32'(ready),        32'(rdy));
    check({tag, ".glitch_count"}, 32'(glitch_count), 32'(g));
  endtask

  // One rising edge; outputs are then observed on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Flip the lines in mask for one cycle; the glitch event lands 3 edges later.
  task automatic glitch_event(input logic [4:0] base, input logic [4:0] mask, input logic clr);
    raw_in = base ^ mask;
    step();
    raw_in = base;
    step();
    step();
    glitch_clr = clr;
    step();
    glitch_clr = 1'b0;
    if (clr) exp_g = 0;
    else     exp_g = (exp_g + $countones(mask) > 255) ? 255 : exp_g + $countones(mask);
  endtask

  initial begin
    // Per-cycle vectors counted from the first edge after reset release.
    add_n(5, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 8'd0); // INIT, masked
    add_n(1, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 1'b1, 8'd0); // load, no pulse
    add_n(5, 5'b01001, 5'b01000, 5'b00000, 5'b00000, 1'b1, 8'd0); // ch0 debouncing
    add_n(1, 5'b01001, 5'b01001, 5'b00001, 5'b00000, 1'b1, 8'd0); // E0+5
    add_n(1, 5'b01001, 5'b01001, 5'b00000, 5'b00000, 1'b1, 8'd0);
    add_n(3, 5'b01101, 5'b01001, 5'b00000, 5'b00000, 1'b1, 8'd0); // 3-cycle bounce
    add_n(2, 5'b01001, 5'b01001, 5'b00000, 5'b00000, 1'b1, 8'd0);
    add_n(2, 5'b01001, 5'b01001, 5'b00000, 5'b00000, 1'b1, 8'd1); // rejected
    add_n(5, 5'b00001, 5'b01001, 5'b00000, 5'b00000, 1'b1, 8'd1);
    add_n(1, 5'b00001, 5'b00001, 5'b00000, 5'b01000, 1'b1, 8'd1); // ch3 falls
    add_n(1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1'b1, 8'd1);
    add_n(5, 5'b10000, 5'b00001, 5'b00000, 5'b00000, 1'b1, 8'd1);
    add_n(1, 5'b10000, 5'b10000, 5'b10000, 5'b00001, 1'b1, 8'd1); // opposite edges
    add_n(1, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 1'b1, 8'd1);

    // Power-up reset.
    #2 rst = 1'b1;
    #1 check_all("reset", 5'b00000, 5'b00000, 5'b00000, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      raw_in = vecs[i].raw;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].rise, vecs[i].fall,
                vecs[i].ready, vecs[i].gcnt);
    end

    // Saturation: clear, preload to 253, then overflow and clear-with-glitch.
    glitch_clr = 1'b1;
    step();
    glitch_clr = 1'b0;
    exp_g = 0;
    check("clr_only", 32'(glitch_count), 32'd0);
    for (int k = 0; k < 50; k++) glitch_event(5'b10000, 5'b11111, 1'b0);
    check("preload_250", 32'(glitch_count), 32'(exp_g));
    glitch_event(5'b10000, 5'b00111, 1'b0);
    check("preload_253", 32'(glitch_count), 32'd253);
    glitch_event(5'b10000, 5'b11100, 1'b0);
    check_all("sat_3ch", 5'b10000, 5'b00000, 5'b00000, 1'b1, 8'd255);
    check("sat_model", 32'(glitch_count), 32'(exp_g));
    glitch_event(5'b10000, 5'b00001, 1'b0);
    check("sat_hold", 32'(glitch_count), 32'd255);
    glitch_event(5'b10000, 5'b00011, 1'b1);
    check("clr_priority", 32'(glitch_count), 32'd0);
    glitch_event(5'b10000, 5'b00100, 1'b0);
    check("post_clr", 32'(glitch_count), 32'd1);

    // Reset with channel 1 PENDING at cnt = 2.
    raw_in = 5'b10010;
    step();
    step();
    step();
    step();
    check("pre_rst_x", 32'(x_out), 32'(5'b10000));
    rst = 1'b1;
    #1 check_all("mid_rst", 5'b00000, 5'b00000, 5'b00000, 1'b0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_all($sformatf("reinit%0d", k), 5'b00000, 5'b00000, 5'b00000, 1'b0, 8'd0);
    end
    step();
    check_all("reinit_load", 5'b10010, 5'b00000, 5'b00000, 1'b1, 8'd0);
    step();
    check_all("reinit_after", 5'b10010, 5'b00000, 5'b00000, 1'b1, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
